add_accumulator: RTL

- Sequential stage directly downstream of sixteen_bit_adder.
- Accepts a burst of LEN 16-bit operands over a valid/ready handshake and accumulates them (add, or subtract from the running total).
- Tracks sticky carry-out and signed-overflow flags.
- Presents the final sum with a valid/ready result handshake.

---
 rtl/add_accumulator.sv | 111 +++++++++++
 1 files changed

// File: rtl/add_accumulator.sv
// Burst accumulator fed by a valid/ready operand stream; adds or subtracts each
// operand into a running total and tracks sticky carry-out and overflow flags.
module add_accumulator #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ci,
  output logic [WIDTH-1:0] acc,
  output logic             co_flag,
  output logic             ov_flag,
  output logic [LEN_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len;
  logic             r_sub;
  logic             r_co;
  logic             r_ov;

  logic [WIDTH-1:0] w_opB;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ov;
  logic             w_accept;
  logic             w_last;

  // Same ripple-add behaviour as the upstream sixteen_bit_adder, one bit wider for carry-out.
  function automatic logic [WIDTH:0] adderFn(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  assign w_opB    = r_sub ? ~in_data : in_data;
  assign w_cin    = r_sub ? 1'b1 : in_ci;
  assign w_sum    = adderFn(r_acc, w_opB, w_cin);
  assign w_ov     = (r_acc[WIDTH-1] == w_opB[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
  assign w_accept = in_valid && (r_state == ACCUM);
  assign w_last   = (r_count == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_sub   <= 1'b0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_count <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_len   <= len;
            r_sub   <= sub;
            r_state <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_count <= r_count + LEN_W'(1);
            r_co    <= r_co | w_sum[WIDTH];
            r_ov    <= r_ov | w_ov;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come straight from state so no input reaches them combinationally.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ACCUM) || (r_state == DONE);
  assign acc       = r_acc;
  assign count     = r_count;
  assign co_flag   = r_co;
  assign ov_flag   = r_ov;

endmodule
